// File: rtl/draw_sprite_rect_pkg.sv
// Shared types and helpers for the draw_sprite_rect stage.
package draw_sprite_rect_pkg;

  // Compare width: one bit wider than the 11-bit coordinates so edge sums never wrap
  localparam int unsigned CMP_W = 12;

  // Width of the outline ring drawn when the border option is built in
  localparam logic [CMP_W-1:0] BORDER_PX = 12'd2;

  // Position handshake FSM encoding
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // True when lo <= val < lo + len, evaluated at CMP_W bits
  function automatic logic in_span(
    input logic [CMP_W-1:0] val,
    input logic [CMP_W-1:0] lo,
    input logic [CMP_W-1:0] len
  );
    logic [CMP_W-1:0] hi;
    hi = lo + len;
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/verilog_macro_bus.vh
// Shared VGA bus definitions: screen constants, bus width, field slices and
// merge/split helpers used by every draw stage in the video pipeline.
// Bus layout (MSB..LSB): hcount[10:0], vcount[10:0], hsync, vsync, hblnk,
// vblnk, rgb[11:0].
`ifndef VERILOG_MACRO_BUS_VH
`define VERILOG_MACRO_BUS_VH

// Screen geometry (800x600@60, 40 MHz pixel clock)
`define SCREEN_W        12'd800
`define SCREEN_H        12'd600
`define COORD_W         11
`define RGB_W           12

// Merged bus width and field positions
`define VGA_BUS_SIZE    38
`define VGA_HCOUNT_BITS 37:27
`define VGA_VCOUNT_BITS 26:16
`define VGA_HSYNC_BIT   15
`define VGA_VSYNC_BIT   14
`define VGA_HBLNK_BIT   13
`define VGA_VBLNK_BIT   12
`define VGA_RGB_BITS    11:0
`define VGA_CTRL_BITS   37:12

// Split helpers: extract one field from a merged bus
`define VGA_HCOUNT(BUS) BUS[`VGA_HCOUNT_BITS]
`define VGA_VCOUNT(BUS) BUS[`VGA_VCOUNT_BITS]
`define VGA_HSYNC(BUS)  BUS[`VGA_HSYNC_BIT]
`define VGA_VSYNC(BUS)  BUS[`VGA_VSYNC_BIT]
`define VGA_HBLNK(BUS)  BUS[`VGA_HBLNK_BIT]
`define VGA_VBLNK(BUS)  BUS[`VGA_VBLNK_BIT]
`define VGA_RGB(BUS)    BUS[`VGA_RGB_BITS]

// Merge helpers: build a bus from fields, or swap only the colour field
`define VGA_MERGE(HC, VC, HS, VS, HB, VB, RGB) {HC, VC, HS, VS, HB, VB, RGB}
`define VGA_MERGE_RGB(BUS, RGB) {BUS[`VGA_CTRL_BITS], RGB}

`endif

// File: rtl/vga_bus_delay.sv
// Fixed-depth register pipeline for the merged VGA bus. Every bit is delayed
// by DEPTH clock cycles; reset clears all stages so the output reads zero.
module vga_bus_delay #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 2
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift the bus one stage per clock; asynchronous clear of every stage
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/draw_sprite_rect.sv
// Draws a solid rectangle over the incoming VGA bus. The rectangle position is
// loaded through a one-entry shadow register (valid/ready handshake) and only
// takes effect at the next vertical blanking rise, so a frame is never torn.
// All bus fields are delayed by two pixel clocks; only rgb is replaced.
// Option: define DRAW_RECT_BORDER_EN to draw BORDER_COLOR on the outer
// 2-pixel ring of the rectangle.
`include "verilog_macro_bus.vh"

module draw_sprite_rect
  import draw_sprite_rect_pkg::*;
#(
  parameter int          RECT_W       = 32,
  parameter int          RECT_H       = 48,
  parameter logic [11:0] RECT_COLOR   = 12'hF00,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
  input  logic                     pclk,
  input  logic                     rst,
  input  logic [`VGA_BUS_SIZE-1:0] vga_in,
  output logic [`VGA_BUS_SIZE-1:0] vga_out,
  input  logic [`COORD_W-1:0]      xpos,
  input  logic [`COORD_W-1:0]      ypos,
  input  logic                     pos_valid,
  output logic                     pos_ready
);

  localparam logic [CMP_W-1:0] RW = CMP_W'(RECT_W);
  localparam logic [CMP_W-1:0] RH = CMP_W'(RECT_H);

  // Incoming bus fields, widened for no-wrap comparisons
  logic [CMP_W-1:0]    hcount_s;
  logic [CMP_W-1:0]    vcount_s;
  logic                hblnk_s;
  logic                vblnk_s;

  // Position handshake state
  logic [0:0]          state_r;
  logic [`COORD_W-1:0] shadow_x_r;
  logic [`COORD_W-1:0] shadow_y_r;
  logic [`COORD_W-1:0] active_x_r;
  logic [`COORD_W-1:0] active_y_r;
  logic                vblnk_prev_r;
  logic                vblnk_rise_s;
  logic                accept_s;

  // Hit detection and colour selection
  logic [CMP_W-1:0]    ax_s;
  logic [CMP_W-1:0]    ay_s;
  logic                on_screen_s;
  logic                hit_s;
  logic                edge_s;
  logic [11:0]         fill_color_s;

  // Two-stage colour pipeline aligned with the bus delay
  logic                fill_s1_r;
  logic [11:0]         color_s1_r;
  logic                fill_s2_r;
  logic [11:0]         color_s2_r;
  logic [`VGA_BUS_SIZE-1:0] bus_dly_s;

  assign hcount_s = {1'b0, `VGA_HCOUNT(vga_in)};
  assign vcount_s = {1'b0, `VGA_VCOUNT(vga_in)};
  assign hblnk_s  = `VGA_HBLNK(vga_in);
  assign vblnk_s  = `VGA_VBLNK(vga_in);

  assign ax_s = {1'b0, active_x_r};
  assign ay_s = {1'b0, active_y_r};

  assign pos_ready    = (state_r == ST_EMPTY);
  assign accept_s     = pos_valid && pos_ready;
  assign vblnk_rise_s = vblnk_s && !vblnk_prev_r;

  // Pass-through pipeline for every bus field
  vga_bus_delay #(
    .WIDTH (`VGA_BUS_SIZE),
    .DEPTH (2)
  ) u_vga_bus_delay (
    .pclk (pclk),
    .rst  (rst),
    .din  (vga_in),
    .dout (bus_dly_s)
  );

  // Position handshake: shadow fill on accept, commit to active on vblnk rise
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_EMPTY;
      shadow_x_r   <= '0;
      shadow_y_r   <= '0;
      active_x_r   <= '0;
      active_y_r   <= '0;
      vblnk_prev_r <= 1'b0;
    end else begin
      vblnk_prev_r <= vblnk_s;
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            if (vblnk_rise_s) begin
              // Accept lands exactly on the frame boundary: use it now
              active_x_r <= xpos;
              active_y_r <= ypos;
            end else begin
              shadow_x_r <= xpos;
              shadow_y_r <= ypos;
              state_r    <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (vblnk_rise_s) begin
            active_x_r <= shadow_x_r;
            active_y_r <= shadow_y_r;
            state_r    <= ST_EMPTY;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // Hit test against the committed position, clipped to the visible area
  always_comb begin
    on_screen_s = !hblnk_s && !vblnk_s &&
                  (hcount_s < `SCREEN_W) && (vcount_s < `SCREEN_H);
    hit_s       = on_screen_s &&
                  in_span(hcount_s, ax_s, RW) &&
                  in_span(vcount_s, ay_s, RH);
    // Outer ring: within BORDER_PX of any rectangle edge
    edge_s      = (hcount_s < (ax_s + BORDER_PX)) ||
                  ((hcount_s + BORDER_PX) >= (ax_s + RW)) ||
                  (vcount_s < (ay_s + BORDER_PX)) ||
                  ((vcount_s + BORDER_PX) >= (ay_s + RH));
  end

`ifdef DRAW_RECT_BORDER_EN
  // Outline colour on the outer ring, fill colour inside
  always_comb begin
    if (edge_s) begin
      fill_color_s = BORDER_COLOR;
    end else begin
      fill_color_s = RECT_COLOR;
    end
  end
`else
  // Whole rectangle in the fill colour; the ring test has no effect here
  logic unused_border_s;
  assign unused_border_s = ^{BORDER_COLOR, edge_s};

  // Solid fill colour for every hit pixel
  always_comb begin
    fill_color_s = RECT_COLOR;
  end
`endif

  // Carry the draw decision alongside the bus through both delay stages
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      fill_s1_r  <= 1'b0;
      color_s1_r <= 12'h000;
      fill_s2_r  <= 1'b0;
      color_s2_r <= 12'h000;
    end else begin
      fill_s1_r  <= hit_s;
      color_s1_r <= fill_color_s;
      fill_s2_r  <= fill_s1_r;
      color_s2_r <= color_s1_r;
    end
  end

  // Replace rgb on hit pixels, pass everything else through untouched
  always_comb begin
    if (fill_s2_r) begin
      vga_out = `VGA_MERGE_RGB(bus_dly_s, color_s2_r);
    end else begin
      vga_out = bus_dly_s;
    end
  end

endmodule

// File: tb/tb_draw_sprite_rect.sv
// Directed testbench for draw_sprite_rect (default parameters). Pixels are
// presented as single synthetic bus words; expected outputs are hand-computed.
// Bus layout: {hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]}.
module tb_draw_sprite_rect;

  localparam logic [11:0] FILL_C = 12'hF00;
`ifdef DRAW_RECT_BORDER_EN
  localparam logic [11:0] EDGE_C = 12'hFFF;
`else
  localparam logic [11:0] EDGE_C = 12'hF00;
`endif

  logic        pclk;
  logic        rst;
  logic [37:0] vga_in;
  logic [37:0] vga_out;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        pos_valid;
  logic        pos_ready;

  int checks = 0;
  int errors = 0;

  draw_sprite_rect dut (
    .pclk      (pclk),
    .rst       (rst),
    .vga_in    (vga_in),
    .vga_out   (vga_out),
    .xpos      (xpos),
    .ypos      (ypos),
    .pos_valid (pos_valid),
    .pos_ready (pos_ready)
  );

  // 40 MHz-style free-running pixel clock
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string tag, input logic [37:0] got, input logic [37:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] mk(input int hc, input int vc, input logic hs, input logic vs,
                                     input logic hb, input logic vb, input logic [11:0] rgb);
    return {11'(hc), 11'(vc), hs, vs, hb, vb, rgb};
  endfunction

  task automatic step();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic check_ready(input string tag, input logic exp);
    check(tag, {37'd0, pos_ready}, {37'd0, exp});
  endtask

  // Present one pixel, wait out the 2-cycle latency, compare the whole bus
  task automatic pix(input string tag, input int hc, input int vc, input logic hb, input logic vb,
                     input logic [11:0] rgb_in, input logic [11:0] exp_rgb);
    vga_in = mk(hc, vc, 1'b1, 1'b0, hb, vb, rgb_in);
    step();
    step();
    check(tag, vga_out, mk(hc, vc, 1'b1, 1'b0, hb, vb, exp_rgb));
  endtask

  // One vblnk low->high->low sequence with blanking asserted
  task automatic vblnk_pulse();
    vga_in = mk(0, 600, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    step();
    vga_in = mk(0, 601, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    step();
    vga_in = mk(0, 602, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    step();
  endtask

  // Load a position from EMPTY and commit it with a vblnk rise
  task automatic commit_pos(input string tag, input int x, input int y);
    vga_in    = mk(0, 650, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    xpos      = 11'(x);
    ypos      = 11'(y);
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    check_ready({tag, "_ready_low"}, 1'b0);
    vga_in = mk(0, 651, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);
    step();
    check_ready({tag, "_ready_high"}, 1'b1);
    vga_in = mk(0, 652, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
    step();
  endtask

  initial begin
    rst       = 1'b1;
    vga_in    = '0;
    xpos      = 11'd0;
    ypos      = 11'd0;
    pos_valid = 1'b0;
    @(negedge pclk);
    step();
    step();

    // Reset state
    check("rst_vga_out", vga_out, 38'd0);
    check_ready("rst_ready", 1'b1);
    rst = 1'b0;
    pix("rst_pos_corner", 0, 0, 1'b0, 1'b0, 12'h123, EDGE_C);
    pix("rst_pos_inner", 5, 5, 1'b0, 1'b0, 12'h123, FILL_C);

    // Position (100,200): hit range hcount 100..131, vcount 200..247
    commit_pos("c100", 100, 200);
    pix("p1_topleft",  100, 200, 1'b0, 1'b0, 12'h0A5, EDGE_C);
    pix("p1_botright", 131, 247, 1'b0, 1'b0, 12'h0A5, EDGE_C);
    pix("p1_inner",    115, 220, 1'b0, 1'b0, 12'h0A5, FILL_C);
    pix("p1_inner_tl", 102, 202, 1'b0, 1'b0, 12'h0A5, FILL_C);
    pix("p1_ring_x101",101, 220, 1'b0, 1'b0, 12'h0A5, EDGE_C);
    pix("p1_ring_x130",130, 220, 1'b0, 1'b0, 12'h0A5, EDGE_C);
    pix("p1_inner_x129",129,220, 1'b0, 1'b0, 12'h0A5, FILL_C);
    pix("p1_ring_y246",115, 246, 1'b0, 1'b0, 12'h0A5, EDGE_C);
    pix("p1_ring_y201",115, 201, 1'b0, 1'b0, 12'h0A5, EDGE_C);
    pix("p1_miss_x99", 99,  200, 1'b0, 1'b0, 12'h0A5, 12'h0A5);
    pix("p1_miss_x132",132, 247, 1'b0, 1'b0, 12'h0A5, 12'h0A5);
    pix("p1_miss_y248",131, 248, 1'b0, 1'b0, 12'h0A5, 12'h0A5);
    pix("p1_miss_y199",100, 199, 1'b0, 1'b0, 12'h0A5, 12'h0A5);
    pix("p1_hblnk",    115, 220, 1'b1, 1'b0, 12'h0A5, 12'h0A5);
    pix("p1_vblnk",    115, 220, 1'b0, 1'b1, 12'h0A5, 12'h0A5);

    // Exact 2-cycle latency: output still shows the older pixel after 1 cycle
    vga_in = mk(99, 200, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123);
    step();
    step();
    vga_in = mk(115, 220, 1'b1, 1'b0, 1'b0, 1'b0, 12'h456);
    step();
    check("lat_1cyc", vga_out, mk(99, 200, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123));
    step();
    check("lat_2cyc", vga_out, mk(115, 220, 1'b1, 1'b0, 1'b0, 1'b0, FILL_C));

    // Position (780,590): clipped to hcount 780..799, vcount 590..599
    commit_pos("c780", 780, 590);
    pix("p2_topleft",  780, 590, 1'b0, 1'b0, 12'h0A5, EDGE_C);
    pix("p2_lastvis",  799, 599, 1'b0, 1'b0, 12'h0A5, FILL_C);
    pix("p2_clip_x800",800, 599, 1'b0, 1'b0, 12'h0A5, 12'h0A5);
    pix("p2_clip_y600",799, 600, 1'b0, 1'b0, 12'h0A5, 12'h0A5);
    pix("p2_miss_x779",779, 590, 1'b0, 1'b0, 12'h0A5, 12'h0A5);
    pix("p2_hblnk",    790, 595, 1'b1, 1'b0, 12'h0A5, 12'h0A5);

    // Mid-frame accept of (10,10): old position stays until vblnk rise
    vga_in    = mk(100, 300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
    xpos      = 11'd10;
    ypos      = 11'd10;
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    check_ready("mid_ready_low", 1'b0);
    pix("mid_old_hit",  785, 592, 1'b0, 1'b0, 12'h0F0, FILL_C);
    pix("mid_new_miss", 20,  20,  1'b0, 1'b0, 12'h0F0, 12'h0F0);
    check_ready("mid_ready_still_low", 1'b0);
    vga_in = mk(0, 600, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    step();
    check_ready("mid_ready_after_vb", 1'b1);
    pix("nf_new_corner", 10,  10,  1'b0, 1'b0, 12'h0F0, EDGE_C);
    pix("nf_new_inner",  20,  20,  1'b0, 1'b0, 12'h0F0, FILL_C);
    pix("nf_old_miss",   785, 592, 1'b0, 1'b0, 12'h0F0, 12'h0F0);

    // pos_valid held while FULL: second value ignored, then accepted
    vga_in    = mk(0, 300, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    xpos      = 11'd300;
    ypos      = 11'd300;
    pos_valid = 1'b1;
    step();
    check_ready("full_ready_low", 1'b0);
    xpos = 11'd50;
    ypos = 11'd50;
    step();
    step();
    step();
    check_ready("full_hold_low", 1'b0);
    vga_in = mk(0, 600, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    step();
    check_ready("full_commit_ready", 1'b1);
    step();
    check_ready("second_accept_low", 1'b0);
    pos_valid = 1'b0;
    pix("first_val_hit",  310, 320, 1'b0, 1'b0, 12'h00F, FILL_C);
    pix("second_val_miss", 60, 60,  1'b0, 1'b0, 12'h00F, 12'h00F);
    vga_in = mk(0, 600, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    step();
    vga_in = mk(0, 601, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    step();
    check_ready("second_commit_ready", 1'b1);
    pix("second_val_hit", 60,  60,  1'b0, 1'b0, 12'h00F, FILL_C);
    pix("first_val_miss", 310, 320, 1'b0, 1'b0, 12'h00F, 12'h00F);

    // Accept coincident with vblnk rise while EMPTY: direct commit
    vga_in = mk(0, 600, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
    step();
    vga_in    = mk(0, 601, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
    xpos      = 11'd400;
    ypos      = 11'd100;
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    check_ready("coinc_ready_high", 1'b1);
    pix("coinc_hit",  410, 120, 1'b0, 1'b0, 12'h0A5, FILL_C);
    pix("coinc_miss", 60,  60,  1'b0, 1'b0, 12'h0A5, 12'h0A5);

    // Reset mid-line with a shadow position in flight
    vga_in    = mk(410, 105, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A5);
    xpos      = 11'd600;
    ypos      = 11'd500;
    pos_valid = 1'b1;
    step();
    pos_valid = 1'b0;
    step();
    #2 rst = 1'b1;
    #1;
    check("midrst_vga_out", vga_out, 38'd0);
    check_ready("midrst_ready", 1'b1);
    step();
    rst = 1'b0;
    pix("postrst_pos_inner", 10,  10,  1'b0, 1'b0, 12'h321, FILL_C);
    pix("postrst_old_miss",  410, 120, 1'b0, 1'b0, 12'h321, 12'h321);
    vblnk_pulse();
    pix("postrst_shadow_gone", 605, 505, 1'b0, 1'b0, 12'h321, 12'h321);
    pix("postrst_still_origin", 10, 10,  1'b0, 1'b0, 12'h321, FILL_C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_sprite_rect.md
DRAW_SPRITE_RECT -- requirements
Module: draw_sprite_rect

Interface
REQ-001 SHALL have parameter RECT_W, default 32, meaning rectangle width in pixels (1..800).
REQ-002 SHALL have parameter RECT_H, default 48, meaning rectangle height in pixels (1..600).
REQ-003 SHALL have parameter RECT_COLOR, default 12'hF00, meaning fill colour (4:4:4 RGB).
REQ-004 SHALL have parameter BORDER_COLOR, default 12'hFFF, meaning outline colour (used only with REQ-024).
REQ-005 SHALL have port pclk, input, 1 bit: pixel clock (40 MHz, 800x600@60).
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port vga_in, input, `VGA_BUS_SIZE bits: merged VGA bus from the timing/previous draw stage (hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]).
REQ-008 SHALL have port vga_out, output, `VGA_BUS_SIZE bits: merged VGA bus to the next stage.
REQ-009 SHALL have port xpos, input, 11 bits: requested rectangle left edge.
REQ-010 SHALL have port ypos, input, 11 bits: requested rectangle top edge.
REQ-011 SHALL have port pos_valid, input, 1 bit: xpos/ypos valid.
REQ-012 SHALL have port pos_ready, output, 1 bit: shadow register empty, able to accept.

Function
REQ-013 SHALL delay every vga_in field by exactly 2 pclk cycles to vga_out; only rgb may be modified.
REQ-014 SHALL treat a pixel as a hit when active_x <= hcount < active_x+RECT_W and active_y <= vcount < active_y+RECT_H, with sums computed at 12 bits (no wrap).
REQ-015 SHALL never draw while hblnk or vblnk is high, or when hcount > 799 or vcount > 599 (clipping); rgb then passes through unchanged.
REQ-016 SHALL output RECT_COLOR on hit, otherwise pass input rgb through.
REQ-017 SHALL accept a position when pos_valid && pos_ready at a rising pclk edge, storing it in a shadow register and dropping pos_ready the next cycle.
REQ-018 SHALL commit shadow to active_x/active_y on the cycle the vblnk input rises (0->1), then raise pos_ready; no change to the active position mid-frame.
REQ-019 SHALL, when accept and vblnk rising edge coincide with an empty shadow, commit the accepted value directly and keep pos_ready high.
REQ-020 SHALL hold pos_ready low and ignore pos_valid while the shadow is full.
REQ-021 SHALL use a 2-state handshake FSM: EMPTY (pos_ready=1) -> FULL on accept without coincident commit; FULL -> EMPTY on vblnk rising edge.

Reset
REQ-022 SHALL, on rst high, immediately clear vga_out to all zeros, set active_x=0, active_y=0, clear shadow, enter EMPTY (pos_ready=1), and clear the vblnk edge detector.
REQ-023 SHALL discard an in-flight accepted-but-uncommitted position on reset; output resumes valid 2 cycles after rst deasserts.

Configuration
REQ-024 SHALL, with macro DRAW_RECT_BORDER_EN defined, draw BORDER_COLOR on the outermost 2-pixel ring of the rectangle and RECT_COLOR inside; without it, the whole rectangle is RECT_COLOR and BORDER_COLOR is unused.

Structure
REQ-025 SHALL take bus width, field slicing, and merge/split macros from the shared verilog_macro_bus.vh header; screen constants (800, 600, 11-bit coordinate width) SHALL live in the same shared header.
REQ-026 SHALL instantiate one sub-module, vga_bus_delay (parameterised depth, here 2), for the pass-through pipeline.

Verification
REQ-027 SHALL pass: reset, pos (100,200) committed; frame scan -> vga_out.rgb=RECT_COLOR exactly at hcount 100..131, vcount 200..247, 2 cycles after matching vga_in.
REQ-028 SHALL pass: pos (780,590) -> drawn only hcount 780..799, vcount 590..599; no colour during blanking.
REQ-029 SHALL pass: accept (10,10) at vcount 300 -> pos_ready low until vblnk rise; old position drawn for rest of frame, new from next frame.
REQ-030 SHALL pass: pos_valid held high with second value (50,50) while FULL -> ignored; first value committed, then (50,50) accepted next cycle.
REQ-031 SHALL pass: rst asserted mid-line -> vga_out=0 same cycle, pos_ready=1, active position (0,0).
REQ-032 SHALL pass with DRAW_RECT_BORDER_EN: pos (100,200) -> hcount 100,101,130,131 and vcount 200,201,246,247 show BORDER_COLOR, interior RECT_COLOR.
